// File: rtl/mem_pkg.sv
// Shared state encoding and default geometry for the dual-port RAM controller family.
package mem_pkg;

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_IDLE = 3'd1,
      ST_WR   = 3'd2,
      ST_RD   = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   localparam int DEF_RAM_WIDTH  = 16;
   localparam int DEF_RAM_DEPTH  = 8;
   localparam int DEF_ADDR_SIZE  = 3;
   localparam int MAX_RD_LATENCY = 4;

   // Read counter spans the enable cycles plus one capture cycle: 0..MAX_RD_LATENCY.
   localparam int LAT_CNT_W = $clog2(MAX_RD_LATENCY + 1);

endpackage

// File: rtl/dual_ram_init_sweep.sv
// Sweep counter: presents one address per enabled cycle, 0..DEPTH-1, wraps to 0 and latches done.
// Single-cycle step; holds its address whenever en is low.
module dual_ram_init_sweep
   import mem_pkg::*;
#(
   parameter int DEPTH = DEF_RAM_DEPTH,
   parameter int AW    = DEF_ADDR_SIZE
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   output logic [AW-1:0] addr,
   output logic          done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [AW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          wrap;

   assign wrap = en && (cnt_q == LAST_ADDR);

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (wrap) begin
         cnt_d  = '0;
         done_d = 1'b1;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign addr = cnt_q;
   assign done = done_q;

endmodule

// File: rtl/dual_ram_port_ctrl.sv
// Drives the dual-port RAM for one client: clears every word after reset, then serves one request at a time.
// Write 1 cycle, read RD_LATENCY+1 cycles to response; req_ready is low while busy and a response holds until rsp_ready.
module dual_ram_port_ctrl
   import mem_pkg::*;
#(
   parameter int                   RAM_WIDTH  = DEF_RAM_WIDTH,
   parameter int                   RAM_DEPTH  = DEF_RAM_DEPTH,
   parameter int                   ADDR_SIZE  = DEF_ADDR_SIZE,
   parameter int                   RD_LATENCY = 1,
   parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [RAM_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [RAM_WIDTH-1:0] rsp_data,
   output logic                 rsp_err,
   output logic                 init_done,
   output logic                 ram_wr_en,
   output logic [ADDR_SIZE-1:0] ram_wr_ad,
   output logic [RAM_WIDTH-1:0] ram_data_in,
   output logic                 ram_rd_en,
   output logic [ADDR_SIZE-1:0] ram_rd_ad,
   input  logic [RAM_WIDTH-1:0] ram_data_out
);

   localparam logic [ADDR_SIZE:0]   DEPTH_LIM   = (ADDR_SIZE + 1)'(RAM_DEPTH);
   localparam logic [LAT_CNT_W-1:0] LAT_CAPTURE = LAT_CNT_W'(RD_LATENCY);
   localparam logic [LAT_CNT_W-1:0] LAT_EN_LAST = LAT_CNT_W'(RD_LATENCY - 1);

   state_t                 state_q, state_d;
   logic [LAT_CNT_W-1:0]   lat_q, lat_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_SIZE-1:0]   wr_ad_q, wr_ad_d;
   logic [RAM_WIDTH-1:0]   din_q, din_d;
   logic                   rd_en_q, rd_en_d;
   logic [ADDR_SIZE-1:0]   rd_ad_q, rd_ad_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [RAM_WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   init_done_q, init_done_d;

   logic                   sweep_en;
   logic                   sweep_done;
   logic [ADDR_SIZE-1:0]   sweep_addr;
   logic                   in_range;

   assign req_ready = (state_q == ST_IDLE);
   assign in_range  = ({1'b0, req_addr} < DEPTH_LIM);
   assign sweep_en  = (state_q == ST_INIT) && !sweep_done;

   dual_ram_init_sweep #(
      .DEPTH (RAM_DEPTH),
      .AW    (ADDR_SIZE)
   ) u_sweep (
      .clk  (clk),
      .clr  (clr),
      .en   (sweep_en),
      .addr (sweep_addr),
      .done (sweep_done)
   );

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      wr_en_d     = 1'b0;
      wr_ad_d     = wr_ad_q;
      din_d       = din_q;
      rd_en_d     = 1'b0;
      rd_ad_d     = rd_ad_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      init_done_d = init_done_q;

      unique case (state_q)
         ST_INIT: begin
            if (sweep_done) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               wr_en_d = 1'b1;
               wr_ad_d = sweep_addr;
               din_d   = INIT_VALUE;
            end
         end
         ST_IDLE: begin
            if (req_valid) begin
               if (req_wr) begin
                  // Out-of-range writes still spend the WR slot, just without an enable.
                  state_d = ST_WR;
                  if (in_range) begin
                     wr_en_d = 1'b1;
                     wr_ad_d = req_addr;
                     din_d   = req_wdata;
                  end
               end else if (in_range) begin
                  state_d = ST_RD;
                  rd_en_d = 1'b1;
                  rd_ad_d = req_addr;
                  lat_d   = '0;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         ST_WR: begin
            state_d = ST_IDLE;
         end
         ST_RD: begin
            // Data lands one cycle after the final enable cycle, so capture on the extra RD cycle.
            if (lat_q == LAT_CAPTURE) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = ram_data_out;
               rsp_err_d   = 1'b0;
            end else begin
               lat_d   = lat_q + 1'b1;
               rd_en_d = (lat_q < LAT_EN_LAST);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= ST_INIT;
         lat_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_ad_q     <= '0;
         din_q       <= '0;
         rd_en_q     <= 1'b0;
         rd_ad_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         wr_en_q     <= wr_en_d;
         wr_ad_q     <= wr_ad_d;
         din_q       <= din_d;
         rd_en_q     <= rd_en_d;
         rd_ad_q     <= rd_ad_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         init_done_q <= init_done_d;
      end
   end

   assign ram_wr_en   = wr_en_q;
   assign ram_wr_ad   = wr_ad_q;
   assign ram_data_in = din_q;
   assign ram_rd_en   = rd_en_q;
   assign ram_rd_ad   = rd_ad_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign init_done   = init_done_q;

endmodule

// File: tb/tb_dual_ram_port_ctrl.sv
// Directed bench: three controllers (defaults, RAM_DEPTH=6, RD_LATENCY=3), each on its own RAM model.
module tb_dual_ram_port_ctrl;

   localparam int N = 3;
   localparam int DEPTHS [N] = '{8, 6, 8};
   localparam int LATS   [N] = '{1, 1, 3};

   logic clk = 1'b0;
   logic clr = 1'b1;

   logic        req_valid    [N];
   logic        req_ready    [N];
   logic        req_wr       [N];
   logic [2:0]  req_addr     [N];
   logic [15:0] req_wdata    [N];
   logic        rsp_valid    [N];
   logic        rsp_ready    [N];
   logic [15:0] rsp_data     [N];
   logic        rsp_err      [N];
   logic        init_done    [N];
   logic        ram_wr_en    [N];
   logic [2:0]  ram_wr_ad    [N];
   logic [15:0] ram_data_in  [N];
   logic        ram_rd_en    [N];
   logic [2:0]  ram_rd_ad    [N];
   logic [15:0] ram_data_out [N];

   logic [15:0] mem  [N][8] = '{default: 16'hBEEF};
   logic [15:0] pipe [N][4] = '{default: 16'h0000};
   int wr_pulses [N] = '{default: 0};
   int rd_pulses [N] = '{default: 0};
   int overlap = 0;
   int cyc     = 0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dual_ram_port_ctrl #(
         .RAM_WIDTH  (16),
         .RAM_DEPTH  (DEPTHS[g]),
         .ADDR_SIZE  (3),
         .RD_LATENCY (LATS[g]),
         .INIT_VALUE (16'h0000)
      ) u_dut (
         .clk          (clk),
         .clr          (clr),
         .req_valid    (req_valid[g]),
         .req_ready    (req_ready[g]),
         .req_wr       (req_wr[g]),
         .req_addr     (req_addr[g]),
         .req_wdata    (req_wdata[g]),
         .rsp_valid    (rsp_valid[g]),
         .rsp_ready    (rsp_ready[g]),
         .rsp_data     (rsp_data[g]),
         .rsp_err      (rsp_err[g]),
         .init_done    (init_done[g]),
         .ram_wr_en    (ram_wr_en[g]),
         .ram_wr_ad    (ram_wr_ad[g]),
         .ram_data_in  (ram_data_in[g]),
         .ram_rd_en    (ram_rd_en[g]),
         .ram_rd_ad    (ram_rd_ad[g]),
         .ram_data_out (ram_data_out[g])
      );
      assign ram_data_out[g] = pipe[g][LATS[g]-1];
   end

   // RAM model: read sampled on the edge after ram_rd_en rises, visible RD_LATENCY edges later.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (ram_wr_en[i] === 1'b1) begin
            mem[i][ram_wr_ad[i]] <= ram_data_in[i];
            wr_pulses[i]         <= wr_pulses[i] + 1;
         end
         if (ram_rd_en[i] === 1'b1) begin
            pipe[i][0]   <= mem[i][ram_rd_ad[i]];
            rd_pulses[i] <= rd_pulses[i] + 1;
         end
         for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
         if (ram_wr_en[i] === 1'b1 && ram_rd_en[i] === 1'b1) overlap <= overlap + 1;
      end
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Presents a request and returns at the negedge after the accepting edge.
   task automatic send(input int d, input bit wr, input logic [2:0] addr,
                       input logic [15:0] wdata, output int acc_cyc);
      int n = 0;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_wr[d]    = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      while (req_ready[d] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("d%0d req_ready_before_accept", d), req_ready[d], 1);
      @(negedge clk);
      req_valid[d] = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_rsp(input int d, output int rsp_cyc);
      int n = 0;
      while (rsp_valid[d] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      rsp_cyc = cyc;
      check($sformatf("d%0d rsp_valid_arrives", d), rsp_valid[d], 1);
   endtask

   task automatic do_write(input int d, input logic [2:0] addr, input logic [15:0] wdata, input bit oor);
      int acc, w0;
      w0 = wr_pulses[d];
      send(d, 1'b1, addr, wdata, acc);
      if (!oor) begin
         check($sformatf("d%0d wr_ad a%0d", d, addr), ram_wr_ad[d], addr);
         check($sformatf("d%0d wr_data a%0d", d, addr), ram_data_in[d], wdata);
      end
      @(negedge clk);
      check($sformatf("d%0d wr_pulses a%0d", d, addr), wr_pulses[d] - w0, oor ? 0 : 1);
   endtask

   task automatic do_read(input int d, input logic [2:0] addr, input logic [15:0] exp, input bit oor);
      int acc, rc, r0;
      r0 = rd_pulses[d];
      send(d, 1'b0, addr, 16'h0, acc);
      wait_rsp(d, rc);
      check($sformatf("d%0d rsp_data a%0d", d, addr), rsp_data[d], exp);
      check($sformatf("d%0d rsp_err a%0d", d, addr), rsp_err[d], oor);
      check($sformatf("d%0d rd_pulses a%0d", d, addr), rd_pulses[d] - r0, oor ? 0 : LATS[d]);
      if (!oor) check($sformatf("d%0d rd_latency a%0d", d, addr), rc - acc, LATS[d] + 1);
      if (rsp_ready[d] === 1'b1) begin
         @(negedge clk);
         check($sformatf("d%0d rsp_valid_drop a%0d", d, addr), rsp_valid[d], 0);
      end
   endtask

   task automatic sweep_check();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         for (int d = 0; d < N; d++) begin
            if (c < DEPTHS[d]) begin
               check($sformatf("d%0d sweep_wr_en c%0d", d, c), ram_wr_en[d], 1);
               check($sformatf("d%0d sweep_wr_ad c%0d", d, c), ram_wr_ad[d], c);
               check($sformatf("d%0d sweep_data c%0d", d, c), ram_data_in[d], 0);
               check($sformatf("d%0d sweep_busy c%0d", d, c), {init_done[d], req_ready[d]}, 0);
            end else if (c == DEPTHS[d]) begin
               check($sformatf("d%0d sweep_end_wr_en", d), ram_wr_en[d], 0);
               check($sformatf("d%0d init_done", d), init_done[d], 1);
               check($sformatf("d%0d ready_after_init", d), req_ready[d], 1);
            end
         end
      end
   endtask

   typedef struct {
      int          d;
      bit          wr;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_data;
      bit          oor;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, rc;
      vecs[0]  = '{0, 1'b1, 3'd0, 16'd9,      16'd0,      1'b0};
      vecs[1]  = '{0, 1'b1, 3'd1, 16'd19,     16'd0,      1'b0};
      vecs[2]  = '{0, 1'b1, 3'd4, 16'd14,     16'd0,      1'b0};
      vecs[3]  = '{0, 1'b1, 3'd6, 16'd25,     16'd0,      1'b0};
      vecs[4]  = '{0, 1'b0, 3'd0, 16'd0,      16'd9,      1'b0};
      vecs[5]  = '{0, 1'b0, 3'd1, 16'd0,      16'd19,     1'b0};
      vecs[6]  = '{0, 1'b0, 3'd4, 16'd0,      16'd14,     1'b0};
      vecs[7]  = '{0, 1'b0, 3'd6, 16'd0,      16'd25,     1'b0};
      vecs[8]  = '{0, 1'b0, 3'd7, 16'd0,      16'd0,      1'b0};
      vecs[9]  = '{1, 1'b1, 3'd7, 16'hAAAA,   16'd0,      1'b1};
      vecs[10] = '{1, 1'b0, 3'd7, 16'd0,      16'd0,      1'b1};
      vecs[11] = '{1, 1'b0, 3'd5, 16'd0,      16'd0,      1'b0};
      vecs[12] = '{1, 1'b1, 3'd2, 16'h1234,   16'd0,      1'b0};
      vecs[13] = '{1, 1'b0, 3'd2, 16'd0,      16'h1234,   1'b0};
      vecs[14] = '{2, 1'b1, 3'd6, 16'd25,     16'd0,      1'b0};
      vecs[15] = '{2, 1'b0, 3'd6, 16'd0,      16'd25,     1'b0};

      for (int d = 0; d < N; d++) begin
         req_valid[d] = 1'b0;
         req_wr[d]    = 1'b0;
         req_addr[d]  = 3'd0;
         req_wdata[d] = 16'd0;
         rsp_ready[d] = 1'b1;
      end

      // Reset state.
      clr = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < N; d++) begin
         check($sformatf("d%0d reset_ctrl", d),
               {req_ready[d], rsp_valid[d], rsp_err[d], init_done[d], ram_wr_en[d], ram_rd_en[d]}, 0);
         check($sformatf("d%0d reset_addr_data", d),
               {ram_wr_ad[d], ram_rd_ad[d], rsp_data[d], ram_data_in[d]}, 0);
      end
      clr = 1'b0;
      sweep_check();

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr) do_write(vecs[i].d, vecs[i].addr, vecs[i].wdata, vecs[i].oor);
         else            do_read(vecs[i].d, vecs[i].addr, vecs[i].exp_data, vecs[i].oor);
      end

      // Response held under backpressure.
      rsp_ready[0] = 1'b0;
      send(0, 1'b0, 3'd4, 16'd0, acc);
      wait_rsp(0, rc);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("hold rsp_valid c%0d", c), rsp_valid[0], 1);
         check($sformatf("hold rsp_data c%0d", c), rsp_data[0], 16'd14);
         check($sformatf("hold req_ready c%0d", c), req_ready[0], 0);
      end
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      check("hold_release rsp_valid", rsp_valid[0], 0);
      check("hold_release req_ready", req_ready[0], 1);

      // Reset while a response is pending, then re-init and read back.
      rsp_ready[0] = 1'b0;
      send(0, 1'b0, 3'd6, 16'd0, acc);
      wait_rsp(0, rc);
      check("pre_clr rsp_data", rsp_data[0], 16'd25);
      clr = 1'b1;
      @(negedge clk);
      check("clr_drop rsp_valid", rsp_valid[0], 0);
      check("clr_drop init_done", init_done[0], 0);
      check("clr_drop req_ready", req_ready[0], 0);
      clr = 1'b0;
      rsp_ready[0] = 1'b1;
      sweep_check();
      do_read(0, 3'd1, 16'd0, 1'b0);

      check("no_wr_rd_overlap", overlap, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
